// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - MIPS decode stage with registered output and one-entry skid buffer
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (flag unrecognised encodings as illegal)
module instruction_decode #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [31:0]     imm_ext,
  output logic [31:0]     jump_target,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch_eq,
  output logic            branch_ne,
  output logic            jump,
  output logic            jump_reg,
  output logic            link,
  output logic            alu_src,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic [2:0]      alu_op,
  output logic            illegal
);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_LUI = 3'd7;

  // Output register (OR) and skid register (SR) state
  logic            r_or_valid;
  logic            r_sr_valid;
  logic [31:0]     r_sr_instr;
  logic [PC_W-1:0] r_sr_pc;
  logic [31:0]     r_instr;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_imm_ext;
  logic [10:0]     r_ctrl;
  logic [2:0]      r_alu_op;
  logic            r_illegal;

  // Handshake and steering
  logic            w_accept;
  logic            w_or_free;
  logic            w_load_or;
  logic [31:0]     w_src_instr;
  logic [PC_W-1:0] w_src_pc;

  // Decoder results
  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic        w_reg_write;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_branch_eq;
  logic        w_branch_ne;
  logic        w_jump;
  logic        w_jump_reg;
  logic        w_link;
  logic        w_alu_src;
  logic        w_mem_to_reg;
  logic        w_reg_dst;
  logic [2:0]  w_alu_op;
  logic        w_zext;
  logic        w_trap;
  logic [31:0] w_imm_ext;
  logic [10:0] w_ctrl;

  assign in_ready  = !r_sr_valid;
  assign w_accept  = in_valid && !r_sr_valid;
  assign w_or_free = !r_or_valid || out_ready;
  // A held SR entry always has priority over the input: in_ready is low while SR is full.
  assign w_load_or = !flush && w_or_free && (r_sr_valid || w_accept);

  assign w_src_instr = r_sr_valid ? r_sr_instr : in_instr;
  assign w_src_pc    = r_sr_valid ? r_sr_pc    : in_pc;
  assign w_op        = w_src_instr[31:26];
  assign w_funct     = w_src_instr[5:0];

  // Decode the selected instruction into control signals; unlisted encodings stay all-zero/ADD
  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_branch_eq  = 1'b0;
    w_branch_ne  = 1'b0;
    w_jump       = 1'b0;
    w_jump_reg   = 1'b0;
    w_link       = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_dst    = 1'b0;
    w_alu_op     = ALU_ADD;
    w_zext       = 1'b0;
    w_trap       = 1'b0;
    case (w_op)
      6'b000000: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
        case (w_funct)
          6'b100000: w_alu_op = ALU_ADD;
          6'b100010: w_alu_op = ALU_SUB;
          6'b100100: w_alu_op = ALU_AND;
          6'b100101: w_alu_op = ALU_OR;
          6'b101010: w_alu_op = ALU_SLT;
          6'b000000: w_alu_op = ALU_SLL;
          6'b000010: w_alu_op = ALU_SRL;
          6'b001000: begin
            w_jump_reg  = 1'b1;
            w_reg_write = 1'b0;
          end
          default: begin
            w_reg_dst   = 1'b0;
            w_reg_write = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            w_trap      = 1'b1;
`endif
          end
        endcase
      end
      6'b100011: begin
        w_alu_src    = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
      end
      6'b101011: begin
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      6'b000100: begin
        w_branch_eq = 1'b1;
        w_alu_op    = ALU_SUB;
      end
      6'b000101: begin
        w_branch_ne = 1'b1;
        w_alu_op    = ALU_SUB;
      end
      6'b001000: begin
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      6'b001100: begin
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_alu_op    = ALU_AND;
        w_zext      = 1'b1;
      end
      6'b001101: begin
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_alu_op    = ALU_OR;
        w_zext      = 1'b1;
      end
      6'b001010: begin
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_alu_op    = ALU_SLT;
      end
      6'b001111: begin
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_alu_op    = ALU_LUI;
      end
      6'b000010: w_jump = 1'b1;
      6'b000011: begin
        w_jump      = 1'b1;
        w_link      = 1'b1;
        w_reg_write = 1'b1;
      end
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        w_trap = 1'b1;
`endif
      end
    endcase
  end

  assign w_imm_ext = w_zext ? {16'h0000, w_src_instr[15:0]}
                            : {{16{w_src_instr[15]}}, w_src_instr[15:0]};

  // A trapped instruction must never write state, whatever the table produced
  assign w_ctrl = {w_reg_write & ~w_trap, w_mem_read & ~w_trap, w_mem_write & ~w_trap,
                   w_branch_eq, w_branch_ne, w_jump, w_jump_reg, w_link,
                   w_alu_src, w_mem_to_reg & ~w_trap, w_reg_dst};

  // Valid bits and skid capture; flush wins over every capture and drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_or_valid <= 1'b0;
      r_sr_valid <= 1'b0;
      r_sr_instr <= '0;
      r_sr_pc    <= '0;
    end else if (flush) begin
      r_or_valid <= 1'b0;
      r_sr_valid <= 1'b0;
    end else if (w_or_free) begin
      r_or_valid <= r_sr_valid || w_accept;
      r_sr_valid <= 1'b0;
    end else if (w_accept) begin
      r_sr_valid <= 1'b1;
      r_sr_instr <= in_instr;
      r_sr_pc    <= in_pc;
    end
  end

  // Decoded bundle register; holds while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr   <= '0;
      r_pc      <= '0;
      r_imm_ext <= '0;
      r_ctrl    <= '0;
      r_alu_op  <= ALU_ADD;
      r_illegal <= 1'b0;
    end else if (w_load_or) begin
      r_instr   <= w_src_instr;
      r_pc      <= w_src_pc;
      r_imm_ext <= w_imm_ext;
      r_ctrl    <= w_ctrl;
      r_alu_op  <= w_alu_op;
      r_illegal <= w_trap;
    end
  end

  assign out_valid   = r_or_valid;
  assign out_pc      = r_pc;
  assign rs          = r_instr[25:21];
  assign rt          = r_instr[20:16];
  assign rd          = r_instr[15:11];
  assign shamt       = r_instr[10:6];
  assign imm_ext     = r_imm_ext;
  assign jump_target = {r_pc[31:28], r_instr[25:0], 2'b00};
  assign {reg_write, mem_read, mem_write, branch_eq, branch_ne, jump, jump_reg, link,
          alu_src, mem_to_reg, reg_dst} = r_ctrl;
  assign alu_op      = r_alu_op;
  assign illegal     = r_illegal;

endmodule
